mem_arbiter: RTL and testbench

Sequences and shares the single main-memory port (memory4c, pipelined reads, fixed read latency) between three requesters: I-cache fill FSM, D-cache fill FSM, and D-cache store write-through.
- Sits between both caches and main memory inside the memory system.
- Converts each fill request into an 8-word burst of pipelined reads and steers returned words to the owner.
- Arbitrates fairly, so neither cache starves.

---
 rtl/mem_pkg.sv | 45 ++++
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arb_rr.sv | 46 ++++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory arbiter: FSM state,
// fill owner and arbitration grant encodings, plus block-address helpers.
package mem_pkg;

  localparam int DWIDTH            = 16;  // data word width
  localparam int AWIDTH            = 16;  // byte address width
  localparam int WORDS             = 8;   // words per cache block
  localparam int MEM_LAT           = 4;   // read issue to mem_valid, in cycles
  localparam int BLOCK_OFFSET_BITS = 4;   // 16-byte block
  localparam int WORD_BITS         = $clog2(WORDS);

  typedef logic [WORD_BITS-1:0] word_idx_t;
  typedef logic [AWIDTH-1:0]    addr_t;
  typedef logic [DWIDTH-1:0]    data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STORE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_I_FILL = 2'd1,
    GNT_D_FILL = 2'd2,
    GNT_D_ST   = 2'd3
  } grant_e;

  // Clear the in-block byte offset so a burst always starts at word 0.
  function automatic addr_t block_base(input addr_t addr);
    return {addr[AWIDTH-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
  endfunction

  // Byte offset of a word inside the block (2-byte words).
  function automatic addr_t word_offset(input word_idx_t idx);
    return addr_t'({idx, 1'b0});
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, fill-return and main-memory signals around the
// arbiter. The arbiter uses the slave view; the caches/memory use master.
interface mem_arbiter_if;
  import mem_pkg::*;

  // Requesters
  logic  i_fill_req;
  addr_t i_fill_addr;
  logic  d_fill_req;
  addr_t d_fill_addr;
  logic  d_st_req;
  addr_t d_st_addr;
  data_t d_st_data;

  // Fill return and store acknowledge
  logic      i_fill_valid;
  logic      d_fill_valid;
  data_t     fill_data;
  word_idx_t fill_word;
  logic      i_fill_done;
  logic      d_fill_done;
  logic      d_st_ack;

  // Main memory port
  logic  mem_en;
  logic  mem_wr;
  addr_t mem_addr;
  data_t mem_wdata;
  data_t mem_rdata;
  logic  mem_valid;

  modport slave (
    input  i_fill_req, i_fill_addr, d_fill_req, d_fill_addr,
           d_st_req, d_st_addr, d_st_data, mem_rdata, mem_valid,
    output i_fill_valid, d_fill_valid, fill_data, fill_word,
           i_fill_done, d_fill_done, d_st_ack,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_fill_req, i_fill_addr, d_fill_req, d_fill_addr,
           d_st_req, d_st_addr, d_st_data, mem_rdata, mem_valid,
    input  i_fill_valid, d_fill_valid, fill_data, fill_word,
           i_fill_done, d_fill_done, d_st_ack,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_rr.sv
// Three-way request picker for the memory port. Stores take priority and
// fills alternate, so an I fill waiting behind a D-side grant goes next.
module mem_arb_rr
  import mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_en,
  input  logic   i_ifill_req,
  input  logic   i_dfill_req,
  input  logic   i_dst_req,
  output grant_e o_grant
);

  owner_e r_last;

  // Choose this cycle's grant; only meaningful while the arbiter is idle.
  always_comb begin
    // NOTE: o_grant gets a default before any branch so no path leaves it unassigned (no latch).
    o_grant = GNT_NONE;
    if (i_en) begin
      if (i_ifill_req && (r_last == OWN_D)) begin
        o_grant = GNT_I_FILL;
      end else if (i_dst_req) begin
        o_grant = GNT_D_ST;
      end else if (i_dfill_req) begin
        o_grant = GNT_D_FILL;
      end else if (i_ifill_req) begin
        o_grant = GNT_I_FILL;
      end
    end
  end

  // Remember which side won most recently; any D-side grant counts as D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= OWN_D;
    end else if (o_grant == GNT_I_FILL) begin
      // NOTE: non-blocking so every flop updates from pre-edge values, independent of block order.
      r_last <= OWN_I;
    end else if (o_grant != GNT_NONE) begin
      r_last <= OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single pipelined main-memory port between I-cache fill,
// D-cache fill and D-cache store write-through. A fill becomes an 8-word
// burst of reads; returned words are steered to the burst owner.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst,   // asynchronous, active-low
  mem_arbiter_if.slave  bus
);

  state_e    r_state;
  state_e    w_state_nxt;
  owner_e    r_owner;
  addr_t     r_base;
  logic [WORD_BITS:0] r_issue_cnt;  // MSB set once all words are issued
  word_idx_t r_ret_cnt;

  grant_e    w_grant;
  logic      w_arb_en;
  logic      w_last_ret;

  logic      w_mem_en;
  logic      w_mem_wr;
  addr_t     w_mem_addr;
  data_t     w_mem_wdata;
  logic      w_i_fill_valid;
  logic      w_d_fill_valid;
  data_t     w_fill_data;
  word_idx_t w_fill_word;
  logic      w_i_fill_done;
  logic      w_d_fill_done;
  logic      w_d_st_ack;

  assign w_arb_en   = (r_state == IDLE);
  assign w_last_ret = (r_state == FILL) && bus.mem_valid &&
                      (r_ret_cnt == word_idx_t'(WORDS - 1));

  mem_arb_rr u_rr (
    .clk         (clk),
    .rst_n       (rst),
    .i_en        (w_arb_en),
    .i_ifill_req (bus.i_fill_req),
    .i_dfill_req (bus.d_fill_req),
    .i_dst_req   (bus.d_st_req),
    .o_grant     (w_grant)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Burst bookkeeping: latch owner and block base on a fill grant, then
  // count issued reads and returned words independently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= OWN_NONE;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant == GNT_I_FILL) begin
            r_owner <= OWN_I;
            r_base  <= block_base(bus.i_fill_addr);
          end else if (w_grant == GNT_D_FILL) begin
            r_owner <= OWN_D;
            r_base  <= block_base(bus.d_fill_addr);
          end
          r_issue_cnt <= '0;
          r_ret_cnt   <= '0;
        end
        FILL: begin
          if (!r_issue_cnt[WORD_BITS]) begin
            r_issue_cnt <= r_issue_cnt + (WORD_BITS + 1)'(1);
          end
          if (bus.mem_valid) begin
            r_ret_cnt <= r_ret_cnt + word_idx_t'(1);
          end
          if (w_last_ret) begin
            r_owner <= OWN_NONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and all port outputs, decoded from the current state.
  always_comb begin
    w_state_nxt    = r_state;
    w_mem_en       = 1'b0;
    w_mem_wr       = 1'b0;
    w_mem_addr     = '0;
    w_mem_wdata    = '0;
    w_i_fill_valid = 1'b0;
    w_d_fill_valid = 1'b0;
    w_fill_data    = '0;
    w_fill_word    = '0;
    w_i_fill_done  = 1'b0;
    w_d_fill_done  = 1'b0;
    w_d_st_ack     = 1'b0;

    case (r_state)
      IDLE: begin
        case (w_grant)
          GNT_I_FILL, GNT_D_FILL: w_state_nxt = FILL;
          GNT_D_ST:               w_state_nxt = STORE;
          default:                w_state_nxt = IDLE;
        endcase
      end

      STORE: begin
        // Store data and address are held by the requester until the ack.
        w_mem_en    = 1'b1;
        w_mem_wr    = 1'b1;
        w_mem_addr  = bus.d_st_addr;
        w_mem_wdata = bus.d_st_data;
        w_d_st_ack  = 1'b1;
        w_state_nxt = IDLE;
      end

      FILL: begin
        if (!r_issue_cnt[WORD_BITS]) begin
          w_mem_en   = 1'b1;
          w_mem_addr = r_base + word_offset(r_issue_cnt[WORD_BITS-1:0]);
        end
        // Returned words go straight through in the mem_valid cycle.
        if (bus.mem_valid) begin
          w_fill_data    = bus.mem_rdata;
          w_fill_word    = r_ret_cnt;
          w_i_fill_valid = (r_owner == OWN_I);
          w_d_fill_valid = (r_owner == OWN_D);
          if (w_last_ret) begin
            w_i_fill_done = (r_owner == OWN_I);
            w_d_fill_done = (r_owner == OWN_D);
            w_state_nxt   = IDLE;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.mem_en       = w_mem_en;
  assign bus.mem_wr       = w_mem_wr;
  assign bus.mem_addr     = w_mem_addr;
  assign bus.mem_wdata    = w_mem_wdata;
  assign bus.i_fill_valid = w_i_fill_valid;
  assign bus.d_fill_valid = w_d_fill_valid;
  assign bus.fill_data    = w_fill_data;
  assign bus.fill_word    = w_fill_word;
  assign bus.i_fill_done  = w_i_fill_done;
  assign bus.d_fill_done  = w_d_fill_done;
  assign bus.d_st_ack     = w_d_st_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a pipelined memory model with fixed read
// latency, a cycle monitor logging port activity, and directed scenarios.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_arbiter_if bus ();

  mem_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory model: a read issued in cycle c returns in cycle c+MEM_LAT with
  // data = block base XOR word index. inject forces a stray mem_valid.
  int    cyc = 0;
  logic  ret_v [16];
  data_t ret_d [16];
  bit    inject = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    bus.mem_valid   = ret_v[cyc % 16] | inject;
    bus.mem_rdata   = inject ? 16'hDEAD : ret_d[cyc % 16];
    ret_v[cyc % 16] = 1'b0;
    #2;
    if (bus.mem_en && !bus.mem_wr) begin
      ret_v[(cyc + MEM_LAT) % 16] = 1'b1;
      ret_d[(cyc + MEM_LAT) % 16] = {bus.mem_addr[15:4], 4'h0} ^ {13'd0, bus.mem_addr[3:1]};
    end
  end

  // Monitor: log what the DUT did in each cycle.
  int iss_a[$], iss_c[$];
  int wr_a[$], wr_d[$], wr_c[$];
  int if_w[$], if_d[$], df_w[$], df_d[$];
  int i_done_cnt, d_done_cnt, ack_cnt;
  int i_done_cyc, d_done_cyc, ack_cyc;
  int bad_done, overlap;

  always @(posedge clk) begin
    #4;
    if (bus.mem_en && !bus.mem_wr) begin
      iss_a.push_back(int'(bus.mem_addr));
      iss_c.push_back(cyc);
    end
    if (bus.mem_en && bus.mem_wr) begin
      wr_a.push_back(int'(bus.mem_addr));
      wr_d.push_back(int'(bus.mem_wdata));
      wr_c.push_back(cyc);
    end
    if (bus.i_fill_valid) begin
      if_w.push_back(int'(bus.fill_word));
      if_d.push_back(int'(bus.fill_data));
    end
    if (bus.d_fill_valid) begin
      df_w.push_back(int'(bus.fill_word));
      df_d.push_back(int'(bus.fill_data));
    end
    if (bus.i_fill_valid && bus.d_fill_valid) overlap++;
    if (bus.i_fill_done) begin
      i_done_cnt++;
      i_done_cyc = cyc;
      if (!(bus.i_fill_valid && bus.fill_word == 3'd7)) bad_done++;
    end
    if (bus.d_fill_done) begin
      d_done_cnt++;
      d_done_cyc = cyc;
      if (!(bus.d_fill_valid && bus.fill_word == 3'd7)) bad_done++;
    end
    if (bus.d_st_ack) begin
      ack_cnt++;
      ack_cyc = cyc;
    end
  end

  task automatic clear_log();
    iss_a.delete(); iss_c.delete();
    wr_a.delete();  wr_d.delete(); wr_c.delete();
    if_w.delete();  if_d.delete(); df_w.delete(); df_d.delete();
    i_done_cnt = 0; d_done_cnt = 0; ack_cnt = 0;
    i_done_cyc = 0; d_done_cyc = 0; ack_cyc = 0;
    bad_done   = 0; overlap    = 0;
  endtask

  // Advance n cycles; returns after the monitor has logged the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #6;
  endtask

  function automatic logic [63:0] outs();
    return {6'd0, bus.i_fill_valid, bus.d_fill_valid, bus.fill_data, bus.fill_word,
            bus.i_fill_done, bus.d_fill_done, bus.d_st_ack, bus.mem_en, bus.mem_wr,
            bus.mem_addr, bus.mem_wdata};
  endfunction

  // Run until the wanted done/ack counts appear, dropping each request on
  // its completion pulse; an expired budget is a failed check.
  task automatic run_until(input string tag, input int budget,
                           input int want_i, input int want_d, input int want_ack);
    int n = 0;
    while (n < budget && !(i_done_cnt >= want_i && d_done_cnt >= want_d && ack_cnt >= want_ack)) begin
      tick(1);
      n++;
      if (want_i   > 0 && i_done_cnt >= want_i)   bus.i_fill_req = 1'b0;
      if (want_d   > 0 && d_done_cnt >= want_d)   bus.d_fill_req = 1'b0;
      if (want_ack > 0 && ack_cnt    >= want_ack) bus.d_st_req   = 1'b0;
    end
    check({tag, "_completed"},
          64'(i_done_cnt >= want_i && d_done_cnt >= want_d && ack_cnt >= want_ack), 64'd1);
  endtask

  // Compare a logged fill against block base XOR word index.
  task automatic check_fill(input string tag, input int base, input bit is_i);
    int w[$];
    int d[$];
    if (is_i) begin w = if_w; d = if_d; end
    else      begin w = df_w; d = df_d; end
    check({tag, "_words"}, 64'(w.size()), 64'd8);
    for (int k = 0; k < 8 && k < w.size(); k++) begin
      check($sformatf("%s_word%0d_idx", tag, k), 64'(w[k]), 64'(k));
      check($sformatf("%s_word%0d_data", tag, k), 64'(d[k]), 64'(base ^ k));
    end
  endtask

  task automatic check_issue(input string tag, input int first, input int base);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_addr%0d", tag, k), 64'(iss_a[first + k]), 64'(base + 2 * k));
    end
    check({tag, "_consecutive"}, 64'(iss_c[first + 7] - iss_c[first]), 64'd7);
  endtask

  initial begin
    int n_iss_rst;
    int n;

    for (int i = 0; i < 16; i++) begin
      ret_v[i] = 1'b0;
      ret_d[i] = '0;
    end
    bus.i_fill_req  = 1'b0; bus.i_fill_addr = '0;
    bus.d_fill_req  = 1'b0; bus.d_fill_addr = '0;
    bus.d_st_req    = 1'b0; bus.d_st_addr   = '0; bus.d_st_data = '0;
    bus.mem_valid   = 1'b0; bus.mem_rdata   = '0;
    clear_log();

    // 1: reset with an I request held, then first access one cycle after release
    bus.i_fill_req  = 1'b1;
    bus.i_fill_addr = 16'h1236;
    tick(2);
    check("rst_outputs_zero", outs(), 64'd0);
    clear_log();
    rst = 1'b1;
    #1;
    check("release_no_mem_en", 64'(bus.mem_en), 64'd0);
    tick(1);
    check("t1_first_mem_en", 64'(bus.mem_en), 64'd1);
    check("t1_first_mem_wr", 64'(bus.mem_wr), 64'd0);
    check("t1_first_addr", 64'(bus.mem_addr), 64'h1230);

    // 2: complete the I burst
    run_until("t2", 40, 1, 0, 0);
    tick(3);
    check("t2_issues", 64'(iss_a.size()), 64'd8);
    check_issue("t2", 0, 'h1230);
    check_fill("t2_ifill", 'h1230, 1'b1);
    check("t2_no_dfill", 64'(df_w.size()), 64'd0);
    check("t2_done_once", 64'(i_done_cnt), 64'd1);
    check("t2_done_on_8th", 64'(bad_done), 64'd0);

    // 3: simultaneous I and D fills after reset: I first, then D
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    clear_log();
    bus.i_fill_req  = 1'b1; bus.i_fill_addr = 16'h2008;
    bus.d_fill_req  = 1'b1; bus.d_fill_addr = 16'h345F;
    run_until("t3", 100, 1, 1, 0);
    tick(2);
    check("t3_issues", 64'(iss_a.size()), 64'd16);
    check_issue("t3_i", 0, 'h2000);
    check_issue("t3_d", 8, 'h3450);
    check_fill("t3_ifill", 'h2000, 1'b1);
    check_fill("t3_dfill", 'h3450, 1'b0);
    check("t3_d_start_after_i_done", 64'(iss_c[8]), 64'(i_done_cyc + 2));
    check("t3_no_overlap", 64'(overlap), 64'd0);
    check("t3_done_on_8th", 64'(bad_done), 64'd0);

    // 4: store raised during an I burst waits for the burst to finish
    clear_log();
    bus.i_fill_req  = 1'b1; bus.i_fill_addr = 16'h0100;
    tick(3);
    bus.d_st_req  = 1'b1;
    bus.d_st_addr = 16'h0040;
    bus.d_st_data = 16'hBEEF;
    run_until("t4", 60, 1, 0, 1);
    tick(2);
    check_fill("t4_ifill", 'h0100, 1'b1);
    check("t4_writes", 64'(wr_a.size()), 64'd1);
    check("t4_wr_addr", 64'(wr_a[0]), 64'h0040);
    check("t4_wr_data", 64'(wr_d[0]), 64'hBEEF);
    check("t4_wr_after_burst", 64'(wr_c[0]), 64'(i_done_cyc + 2));
    check("t4_ack_with_write", 64'(ack_cyc), 64'(wr_c[0]));
    check("t4_ack_once", 64'(ack_cnt), 64'd1);

    // 5: stray mem_valid while idle, then D fill with req dropped mid-burst
    clear_log();
    tick(2);
    inject = 1'b1;
    tick(1);
    inject = 1'b0;
    tick(2);
    check("t5_stray_ignored", 64'(if_w.size() + df_w.size()), 64'd0);
    bus.d_fill_req  = 1'b1; bus.d_fill_addr = 16'h7772;
    tick(4);
    bus.d_fill_req = 1'b0;
    run_until("t5", 40, 0, 1, 0);
    tick(2);
    check_fill("t5_dfill", 'h7770, 1'b0);
    check("t5_d_done_once", 64'(d_done_cnt), 64'd1);
    check("t5_no_ifill", 64'(if_w.size()), 64'd0);
    check("t5_done_on_8th", 64'(bad_done), 64'd0);

    // 6: reset asserted on the 3rd return of a D fill
    clear_log();
    bus.d_fill_req  = 1'b1; bus.d_fill_addr = 16'h999A;
    n = 0;
    while (n < 30 && df_w.size() < 3) begin
      tick(1);
      n++;
    end
    check("t6_reached_3rd_word", 64'(df_w.size()), 64'd3);
    rst = 1'b0;
    #1;
    check("t6_async_rst_outputs", outs(), 64'd0);
    bus.d_fill_req = 1'b0;
    n_iss_rst = iss_a.size();
    tick(2);
    rst = 1'b1;
    tick(10);
    check("t6_no_new_issue", 64'(iss_a.size()), 64'(n_iss_rst));
    check("t6_no_write", 64'(wr_a.size()), 64'd0);
    check("t6_late_valid_ignored", 64'(df_w.size()), 64'd3);
    check("t6_no_done", 64'(d_done_cnt), 64'd0);
    check("t6_idle_outputs", outs(), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
